// File: rtl/cube_pkg.sv
// ============================================================================
// Package     : cube_pkg
// Description : Shared state encoding and cube edge ROM for the per-frame
//               cube draw scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cube_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLEAR     = 4'd1,
    PROJ      = 4'd2,
    FETCH_A   = 4'd3,
    FETCH_B   = 4'd4,
    LATCH     = 4'd5,
    DRAW      = 4'd6,
    WAIT_LINE = 4'd7,
    SWAP      = 4'd8
  } sched_state_t;

  localparam int N_EDGES = 12;

  // Edge k joins vertex EDGE_A[k] to vertex EDGE_B[k]: front face, back face, then the four connectors
  localparam logic [2:0] EDGE_A [0:N_EDGES-1] = '{
    3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd7, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3
  };
  localparam logic [2:0] EDGE_B [0:N_EDGES-1] = '{
    3'd1, 3'd3, 3'd2, 3'd0, 3'd5, 3'd7, 3'd6, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7
  };

endpackage

`default_nettype wire

// File: rtl/cube_draw_sched.sv
// ============================================================================
// Module      : cube_draw_sched
// Description : Per-frame scheduler for the VGA cube renderer: clear, project,
//               draw 12 edges, swap buffers, advance the rotation angle.
//               Optional macro CUBE_SCHED_OVERRUN_CNT_EN builds the frame
//               overrun counter; otherwise overrun_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_draw_sched
  import cube_pkg::*;
#(
  parameter int CORDW    = 10,
  parameter int ANGW     = 8,
  parameter int ANG_STEP = 1
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             clk_locked,
  input  logic             frame_start,
  output logic             clr_start,
  input  logic             clr_done,
  output logic             proj_start,
  output logic [ANGW-1:0]  proj_angle,
  input  logic             proj_done,
  output logic [2:0]       vtx_idx,
  input  logic [CORDW-1:0] vtx_x,
  input  logic [CORDW-1:0] vtx_y,
  output logic             line_start,
  output logic [CORDW-1:0] x0,
  output logic [CORDW-1:0] y0,
  output logic [CORDW-1:0] x1,
  output logic [CORDW-1:0] y1,
  input  logic             line_busy,
  input  logic             line_done,
  output logic             buf_swap,
  output logic             busy,
  output logic [7:0]       overrun_cnt
);

  localparam logic [ANGW-1:0] c_ang_step  = ANGW'(ANG_STEP);
  localparam logic [3:0]      c_last_edge = 4'(N_EDGES - 1);

  sched_state_t r_state;
  logic [3:0]   r_edge;
  logic [3:0]   w_edge_nxt;

  assign w_edge_nxt = r_edge + 4'd1;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_edge     <= 4'd0;
      clr_start  <= 1'b0;
      proj_start <= 1'b0;
      line_start <= 1'b0;
      buf_swap   <= 1'b0;
      proj_angle <= '0;
      vtx_idx    <= 3'd0;
      x0         <= '0;
      y0         <= '0;
      x1         <= '0;
      y1         <= '0;
    end else begin
      clr_start  <= 1'b0;
      proj_start <= 1'b0;
      line_start <= 1'b0;
      buf_swap   <= 1'b0;
      // Lost PLL lock abandons the frame but keeps angle and edge position
      if (!clk_locked) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (frame_start) begin
              clr_start <= 1'b1;
              r_state   <= CLEAR;
            end
          end
          CLEAR: begin
            if (clr_done) begin
              proj_start <= 1'b1;
              r_state    <= PROJ;
            end
          end
          PROJ: begin
            if (proj_done) begin
              r_edge  <= 4'd0;
              vtx_idx <= EDGE_A[0];
              r_state <= FETCH_A;
            end
          end
          // Vertex RAM answers one cycle after the index, so the index leads the latch by a state
          FETCH_A: begin
            vtx_idx <= EDGE_B[r_edge];
            r_state <= FETCH_B;
          end
          FETCH_B: begin
            x0      <= vtx_x;
            y0      <= vtx_y;
            r_state <= LATCH;
          end
          LATCH: begin
            x1      <= vtx_x;
            y1      <= vtx_y;
            r_state <= DRAW;
          end
          DRAW: begin
            if (!line_busy) begin
              line_start <= 1'b1;
              r_state    <= WAIT_LINE;
            end
          end
          WAIT_LINE: begin
            if (line_done) begin
              if (r_edge == c_last_edge) begin
                buf_swap <= 1'b1;
                r_state  <= SWAP;
              end else begin
                r_edge  <= w_edge_nxt;
                vtx_idx <= EDGE_A[w_edge_nxt];
                r_state <= FETCH_A;
              end
            end
          end
          SWAP: begin
            proj_angle <= proj_angle + c_ang_step;
            r_state    <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef CUBE_SCHED_OVERRUN_CNT_EN
  logic [7:0] r_overrun_cnt;

  // A frame_start that arrives while a frame is in flight is dropped and counted
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      r_overrun_cnt <= 8'd0;
    end else if (frame_start && (r_state != IDLE) && (r_overrun_cnt != 8'hFF)) begin
      r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end

  assign overrun_cnt = r_overrun_cnt;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cube_draw_sched.sv
// ============================================================================
// Module      : tb_cube_draw_sched
// Description : Self-checking bench for cube_draw_sched with randomized vertex
//               data and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_draw_sched;

  localparam int CORDW = 10;
  localparam int ANGW  = 8;
`ifdef CUBE_SCHED_OVERRUN_CNT_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  logic             clk_pix = 1'b0;
  logic             rst, clk_locked, frame_start, line_busy;
  logic             clr_done = 1'b0, pd_auto = 1'b0, pd_man = 1'b0, line_done = 1'b0;
  logic             proj_done;
  logic             clr_start, proj_start, line_start, buf_swap, busy;
  logic [ANGW-1:0]  proj_angle;
  logic [2:0]       vtx_idx;
  logic [CORDW-1:0] vtx_x = '0, vtx_y = '0, x0, y0, x1, y1;
  logic [7:0]       overrun_cnt;

  always #5 clk_pix = ~clk_pix;
  assign proj_done = pd_auto | pd_man;

  cube_draw_sched #(.CORDW(CORDW), .ANGW(ANGW), .ANG_STEP(1)) dut (
    .clk_pix(clk_pix), .rst(rst), .clk_locked(clk_locked), .frame_start(frame_start),
    .clr_start(clr_start), .clr_done(clr_done), .proj_start(proj_start),
    .proj_angle(proj_angle), .proj_done(proj_done), .vtx_idx(vtx_idx),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .line_start(line_start), .x0(x0), .y0(y0),
    .x1(x1), .y1(y1), .line_busy(line_busy), .line_done(line_done),
    .buf_swap(buf_swap), .busy(busy), .overrun_cnt(overrun_cnt)
  );

  // Cube wireframe: front face, back face, connectors
  int ea [12] = '{0, 1, 3, 2, 4, 5, 7, 6, 0, 1, 2, 3};
  int eb [12] = '{1, 3, 2, 0, 5, 7, 6, 4, 4, 5, 6, 7};

  logic [CORDW-1:0]   vx [8];
  logic [CORDW-1:0]   vy [8];
  logic [4*CORDW-1:0] lq [$];
  int checks = 0, errors = 0, exp_ang = 0;
  int n_ls = 0, n_swap = 0, n_clr = 0, n_ps = 0, n_pd = 0, n_x = 0;
  int clr_cnt = 0, pd_cnt = 0, ln_cnt = 0;
  bit proj_en = 1'b1, mon_en = 1'b0;

  // Projected-vertex RAM: one cycle read latency
  always @(posedge clk_pix) begin
    vtx_x <= vx[vtx_idx];
    vtx_y <= vy[vtx_idx];
  end

  // Clear (5 cycles), projection (10 cycles) and line engine (4 cycles) responders
  always @(posedge clk_pix) begin
    clr_done  <= 1'b0;
    pd_auto   <= 1'b0;
    line_done <= 1'b0;
    if (clr_start === 1'b1) clr_cnt <= 4;
    else if (clr_cnt != 0) begin
      clr_cnt <= clr_cnt - 1;
      if (clr_cnt == 1) clr_done <= 1'b1;
    end
    if (proj_start === 1'b1 && proj_en) pd_cnt <= 9;
    else if (pd_cnt != 0) begin
      pd_cnt <= pd_cnt - 1;
      if (pd_cnt == 1) pd_auto <= 1'b1;
    end
    if (line_start === 1'b1) ln_cnt <= 3;
    else if (ln_cnt != 0) begin
      ln_cnt <= ln_cnt - 1;
      if (ln_cnt == 1) line_done <= 1'b1;
    end
  end

  always @(negedge clk_pix) begin
    if (mon_en) begin
      if (line_start === 1'b1) begin
        lq.push_back({x0, y0, x1, y1});
        n_ls++;
      end
      if (buf_swap === 1'b1)   n_swap++;
      if (clr_start === 1'b1)  n_clr++;
      if (proj_start === 1'b1) n_ps++;
      if (proj_done === 1'b1)  n_pd++;
      if ($isunknown({clr_start, proj_start, proj_angle, vtx_idx, line_start,
                      x0, y0, x1, y1, buf_swap, busy, overrun_cnt})) n_x++;
    end
  end

  task automatic tick();
    @(negedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    lq.delete();
    n_ls = 0; n_swap = 0; n_clr = 0; n_ps = 0; n_pd = 0;
  endtask

  task automatic frame_begin();
    for (int v = 0; v < 8; v++) begin
      vx[v] = CORDW'($urandom_range(0, 1023));
      vy[v] = CORDW'($urandom_range(0, 1023));
    end
    clr_mon();
    chk("angle_pre", 64'(proj_angle), 64'(exp_ang));
    chk("idle_pre", 64'(busy), 64'(0));
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("clr_start_lat", 64'(clr_start), 64'(1));
  endtask

  task automatic frame_end();
    logic [4*CORDW-1:0] exp_l, got_l;
    for (int i = 0; i < 4000 && n_swap == 0; i++) tick();
    chk("swap_seen", 64'(n_swap), 64'(1));
    tick();
    chk("line_count", 64'(n_ls), 64'(12));
    chk("clr_count", 64'(n_clr), 64'(1));
    chk("swap_count", 64'(n_swap), 64'(1));
    for (int e = 0; e < 12; e++) begin
      exp_l = {vx[ea[e]], vy[ea[e]], vx[eb[e]], vy[eb[e]]};
      got_l = (e < lq.size()) ? lq[e] : 'x;
      chk($sformatf("line%0d", e), 64'(got_l), 64'(exp_l));
    end
    exp_ang = (exp_ang + 1) % 256;
    chk("angle_post", 64'(proj_angle), 64'(exp_ang));
    chk("busy_post", 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b0; clk_locked = 1'b1; frame_start = 1'b0; line_busy = 1'b0;
    for (int v = 0; v < 8; v++) begin vx[v] = '0; vy[v] = '0; end
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pulses", 64'({clr_start, proj_start, line_start, buf_swap}), 64'(0));
    chk("rst_coords", 64'({x0, y0, x1, y1}), 64'(0));
    chk("rst_vtx_ang", 64'({vtx_idx, proj_angle}), 64'(0));
    chk("rst_ovr", 64'(overrun_cnt), 64'(0));
    rst = 1'b1; mon_en = 1'b1;
    tick();

    // Normal frame
    frame_begin();
    frame_end();

    // frame_start without PLL lock is not accepted
    clk_locked = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("nolock_clr", 64'(clr_start), 64'(0));
    tick();
    chk("nolock_busy", 64'(busy), 64'(0));
    clk_locked = 1'b1;
    tick();

    // Line engine back-pressure
    line_busy = 1'b1;
    frame_begin();
    for (int i = 0; i < 200 && n_pd == 0; i++) tick();
    chk("bp_proj_done", 64'(n_pd), 64'(1));
    for (int i = 0; i < 25; i++) tick();
    chk("bp_hold_count", 64'(n_ls), 64'(0));
    chk("bp_hold_now", 64'(line_start), 64'(0));
    line_busy = 1'b0;
    tick();
    chk("bp_release", 64'(line_start), 64'(1));
    frame_end();

    // Overrun during WAIT_LINE
    frame_begin();
    for (int i = 0; i < 200 && n_ls == 0; i++) tick();
    tick(); tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_no_clr", 64'(clr_start), 64'(0));
    frame_end();
    chk("ovr_cnt", 64'(overrun_cnt), 64'(EXP_OVR));

    // Asynchronous reset mid-WAIT_LINE
    frame_begin();
    for (int i = 0; i < 500 && n_ls < 3; i++) tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_outs", 64'({clr_start, proj_start, line_start, buf_swap, vtx_idx, proj_angle}), 64'(0));
    chk("arst_coords", 64'({x0, y0, x1, y1}), 64'(0));
    chk("arst_ovr", 64'(overrun_cnt), 64'(0));
    tick(); tick();
    rst = 1'b1;
    clr_mon();
    for (int i = 0; i < 20; i++) tick();
    chk("arst_no_swap", 64'(n_swap), 64'(0));
    exp_ang = 0;
    frame_begin();
    frame_end();

    // Lock lost in PROJ; late proj_done ignored
    proj_en = 1'b0;
    frame_begin();
    for (int i = 0; i < 100 && n_ps == 0; i++) tick();
    chk("lock_proj_start", 64'(n_ps), 64'(1));
    tick(); tick();
    clk_locked = 1'b0;
    tick();
    chk("lock_idle", 64'(busy), 64'(0));
    chk("lock_pulses", 64'({clr_start, proj_start, line_start, buf_swap}), 64'(0));
    clk_locked = 1'b1; pd_man = 1'b1;
    tick();
    pd_man = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("late_pd_busy", 64'(busy), 64'(0));
    chk("late_pd_lines", 64'(n_ls), 64'(0));
    chk("lock_angle_held", 64'(proj_angle), 64'(exp_ang));
    proj_en = 1'b1;
    frame_begin();
    frame_end();

    // Angle wrap over 256 frames from reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_ang = 0;
    tick();
    for (int f = 0; f < 256; f++) begin
      frame_begin();
      frame_end();
    end
    chk("angle_wrap", 64'(proj_angle), 64'(0));
    chk("no_x", 64'(n_x), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
